max_pool: RTL and testbench

Per-lane signed max-pooling stage that sits directly downstream of `activation` and consumes its `out_data` / `out_data_available` stream. It reduces each run of 1, 2 or 4 consecutive valid rows to a single row by taking the per-lane maximum, then hands the pooled rows to the output writeback. When disabled it forwards the activation stream with one register stage, so the downstream timing is the same in both modes.

---
 rtl/max_pool_if.sv | 21 ++
 rtl/max_pool.sv | 128 ++++++++++++
 tb/tb_max_pool.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/max_pool_if.sv
// Row stream between activation and max_pool, plus the pooled output stream.
interface max_pool_if #(
  parameter int DWIDTH      = 8,
  parameter int DESIGN_SIZE = 4
);
  logic                          in_data_available;
  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data;
  logic [DESIGN_SIZE*DWIDTH-1:0] out_data;
  logic                          out_data_available;
  logic                          done_pool;

  modport master (
    output in_data_available, inp_data,
    input  out_data, out_data_available, done_pool
  );

  modport slave (
    input  in_data_available, inp_data,
    output out_data, out_data_available, done_pool
  );
endinterface

// File: rtl/max_pool.sv
// Per-lane signed max pooling over windows of 1/2/4 consecutive rows.
// When disabled, the activation stream passes through one register stage.
module max_pool #(
  parameter int DWIDTH      = 8,
  parameter int DESIGN_SIZE = 4,
  parameter int MASK_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_pool,
  input  logic [1:0]            pool_window,
  input  logic [MASK_WIDTH-1:0] validity_mask,
  max_pool_if.slave             bus
);
  localparam int RW = DESIGN_SIZE * DWIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   acc, acc_nxt, merged, emit_row, masked, out_q;
  logic [2:0]      cnt, cnt_nxt, cnt_inc, win, win_nxt, win_sel;
  logic            emit, oda_q;

  always_comb begin
    case (pool_window)
      2'd0:    win_sel = 3'd1;
      2'd1:    win_sel = 3'd2;
      default: win_sel = 3'd4;
    endcase
  end

  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < DESIGN_SIZE; i++) begin
      merged[i*DWIDTH +: DWIDTH] =
        ($signed(acc[i*DWIDTH +: DWIDTH]) > $signed(bus.inp_data[i*DWIDTH +: DWIDTH]))
          ? acc[i*DWIDTH +: DWIDTH] : bus.inp_data[i*DWIDTH +: DWIDTH];
    end
  end

  assign cnt_inc = cnt + 3'd1;

  // A completing beat is emitted on the same edge it is accumulated; cnt==0
  // inside ACCUM means the previous window just closed, so the beat seeds afresh.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    win_nxt   = win;
    emit      = 1'b0;
    emit_row  = acc;
    if (!enable_pool) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_data_available) begin
            acc_nxt   = bus.inp_data;
            win_nxt   = win_sel;
            state_nxt = ACCUM;
            if (win_sel == 3'd1) begin
              emit     = 1'b1;
              emit_row = bus.inp_data;
              cnt_nxt  = '0;
            end else begin
              cnt_nxt = 3'd1;
            end
          end
        end
        ACCUM: begin
          if (bus.in_data_available) begin
            acc_nxt = (cnt == 3'd0) ? bus.inp_data : merged;
            if (cnt_inc == win) begin
              emit     = 1'b1;
              emit_row = acc_nxt;
              cnt_nxt  = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            emit      = (cnt != 3'd0);
            cnt_nxt   = '0;
            state_nxt = FLUSH;
          end
        end
        FLUSH:   state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < DESIGN_SIZE; i++) begin
      if (validity_mask[i]) masked[i*DWIDTH +: DWIDTH] = emit_row[i*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      win   <= 3'd1;
      out_q <= '0;
      oda_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      win   <= win_nxt;
      if (!enable_pool) begin
        out_q <= bus.inp_data;
        oda_q <= bus.in_data_available;
      end else if (emit) begin
        out_q <= masked;
        oda_q <= 1'b1;
      end else begin
        oda_q <= 1'b0;
      end
    end
  end

  assign bus.out_data           = out_q;
  assign bus.out_data_available = oda_q;
  assign bus.done_pool          = enable_pool ? (state == DONE) : 1'b1;
endmodule

// File: tb/tb_max_pool.sv
// Directed and random checks of max_pool against a window-based reference model.
module tb_max_pool;
  localparam int DW = 8;
  localparam int DS = 4;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_pool;
  logic [1:0]  pool_window;
  logic [3:0]  validity_mask;
  int          total = 0;
  int          bad = 0;
  logic [31:0] rows[$];

  max_pool_if #(.DWIDTH(DW), .DESIGN_SIZE(DS)) bus ();

  max_pool #(.DWIDTH(DW), .DESIGN_SIZE(DS), .MASK_WIDTH(MW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_pool  (enable_pool),
    .pool_window  (pool_window),
    .validity_mask(validity_mask),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-lane signed maximum of rows[first..last], then masked.
  function automatic logic [31:0] window_max(input int first, input int last, input logic [3:0] mask);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int          m;
      logic [31:0] x;
      x = rows[first];
      m = $signed(x[i*8 +: 8]);
      for (int j = first + 1; j <= last; j++) begin
        x = rows[j];
        if ($signed(x[i*8 +: 8]) > m) m = $signed(x[i*8 +: 8]);
      end
      if (mask[i]) r[i*8 +: 8] = m[7:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams rows[] as one burst and checks every following cycle.
  task automatic run_pool(input int wcode, input logic [3:0] mask, input string tag);
    int n, w, idx;
    bit pulse;
    n = rows.size();
    w = (wcode == 0) ? 1 : (wcode == 1) ? 2 : 4;
    pool_window = wcode[1:0];
    validity_mask = mask;
    bus.in_data_available = 1'b1;
    bus.inp_data = rows[0];
    for (int k = 1; k <= n + 3; k++) begin
      tick();
      pulse = (k <= n && k % w == 0) || (k == n + 1 && n % w != 0);
      chk($sformatf("%s_avail_c%0d", tag, k), 32'(bus.out_data_available), 32'(pulse));
      chk($sformatf("%s_done_c%0d", tag, k), 32'(bus.done_pool), 32'(k == n + 2));
      if (pulse) begin
        idx = (k <= n) ? k : n;
        chk($sformatf("%s_data_c%0d", tag, k), bus.out_data,
            window_max(((idx - 1) / w) * w, idx - 1, mask));
      end
      pool_window = 2'($urandom);
      if (k < n) begin
        bus.inp_data = rows[k];
        bus.in_data_available = 1'b1;
      end else begin
        bus.in_data_available = 1'b0;
        bus.inp_data = $urandom;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    enable_pool = 1'b1;
    pool_window = 2'd0;
    validity_mask = 4'hF;
    bus.in_data_available = 1'b0;
    bus.inp_data = '0;
    #1;
    chk("reset_data", bus.out_data, 32'h0);
    chk("reset_avail", 32'(bus.out_data_available), 32'h0);
    chk("reset_done", 32'(bus.done_pool), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    rows = '{mk(1, -3, 5, 127), mk(2, -4, -6, -128)};
    chk("w2_model", window_max(0, 1, 4'hF), mk(2, -3, 5, 127));
    run_pool(1, 4'hF, "w2");

    rows.delete();
    foreach (rows[i]) rows.delete(i);
    rows.push_back(mk(10, 1, 2, 3));
    rows.push_back(mk(-1, 4, 5, 6));
    rows.push_back(mk(30, -7, 8, 9));
    rows.push_back(mk(7, 10, -11, 12));
    rows.push_back(mk(-9, 13, 14, -15));
    run_pool(2, 4'hF, "w4");

    rows = '{mk(9, 9, 9, 9)};
    chk("w1_model", window_max(0, 0, 4'b0101), mk(9, 0, 9, 0));
    run_pool(0, 4'b0101, "w1");

    for (int r = 0; r < 8; r++) begin
      int n;
      rows.delete();
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) rows.push_back($urandom);
      run_pool($urandom_range(0, 3), 4'($urandom), $sformatf("rand%0d", r));
    end

    // Bypass: registered pass-through, no masking, done held high.
    enable_pool = 1'b0;
    validity_mask = 4'b0000;
    rows = '{32'($urandom) | 32'h1, 32'($urandom) | 32'h1, 32'($urandom) | 32'h1};
    for (int k = 0; k < 4; k++) begin
      bus.in_data_available = (k < 3);
      if (k < 3) bus.inp_data = rows[k];
      tick();
      chk($sformatf("byp_avail_%0d", k), 32'(bus.out_data_available), 32'(k < 3));
      chk($sformatf("byp_done_%0d", k), 32'(bus.done_pool), 32'h1);
      chk($sformatf("byp_data_%0d", k), bus.out_data, rows[(k < 3) ? k : 2]);
    end
    enable_pool = 1'b1;
    validity_mask = 4'hF;
    tick();

    // Asynchronous reset between edges after the third beat of a W=4 burst.
    pool_window = 2'd2;
    for (int k = 0; k < 3; k++) begin
      bus.in_data_available = 1'b1;
      bus.inp_data = $urandom;
      tick();
    end
    bus.in_data_available = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_data", bus.out_data, 32'h0);
    chk("arst_avail", 32'(bus.out_data_available), 32'h0);
    chk("arst_done", 32'(bus.done_pool), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    rows = '{mk(4, 4, 4, 4), mk(6, 6, 6, 6)};
    chk("arst_model", window_max(0, 1, 4'hF), mk(6, 6, 6, 6));
    run_pool(1, 4'hF, "after_rst");

    // Abort: enable_pool dropped after the first beat of a W=2 burst.
    pool_window = 2'd1;
    bus.in_data_available = 1'b1;
    bus.inp_data = $urandom;
    tick();
    enable_pool = 1'b0;
    bus.in_data_available = 1'b0;
    tick();
    chk("abort_avail_off", 32'(bus.out_data_available), 32'h0);
    enable_pool = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("abort_avail_%0d", k), 32'(bus.out_data_available), 32'h0);
      chk($sformatf("abort_done_%0d", k), 32'(bus.done_pool), 32'h0);
    end
    rows = '{32'($urandom), 32'($urandom), 32'($urandom)};
    run_pool(0, 4'hF, "post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
